// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS store buffer
package mips_pkg;

  // One buffered store: address and data as issued by the core
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } store_req_t;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_MASK_DEFAULT = 32'hFFFF_0000;

  // Occupancy classification derived from the entry count
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;

endpackage

// File: rtl/store_fifo_mem.sv
// rtl/store_fifo_mem.sv - DEPTH x 64-bit store storage, sync write, async read, no reset
module store_fifo_mem
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PW-1:0]    waddr_i,
  input  store_req_t       wdata_i,
  input  logic [PW-1:0]    raddr_i,
  output store_req_t       rdata_o
);

  store_req_t mem_q [DEPTH];

  // Write port: capture one store per enabled cycle; contents are not reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mips_store_buffer.sv
// rtl/mips_store_buffer.sv - store capture FIFO draining core stores to a slower bus (option: MIPS_STORE_BUF_FILTER_EN)
module mips_store_buffer
  import mips_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
  parameter logic [31:0] MMIO_MASK = MMIO_MASK_DEFAULT,
  localparam int         PW        = $clog2(DEPTH),
  localparam int         CW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [31:0]   dataadr,
  input  logic [31:0]   writedata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_addr,
  output logic [31:0]   out_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  input  logic          clear_overflow
);

`ifdef MIPS_STORE_BUF_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  occ_state_t    occ;
  logic          in_window, cand, push, pop, drop;
  store_req_t    wr_entry, head;

  // Classify occupancy from the count; full/empty/valid all follow from it
  always_comb begin
    occ = OCC_PARTIAL;
    if (count_q == '0) begin
      occ = OCC_EMPTY;
    end else if (count_q == CW'(DEPTH)) begin
      occ = OCC_FULL;
    end
  end

  assign empty     = (occ == OCC_EMPTY);
  assign full      = (occ == OCC_FULL);
  assign out_valid = !empty;

  // With the filter off every store is a candidate; the window compare folds away
  assign in_window = ((dataadr & MMIO_MASK) == MMIO_BASE);
  assign cand      = memwrite & (!FILTER_EN | in_window);
  assign pop       = out_valid & out_ready;
  assign push      = cand & (!full | pop);
  assign drop      = cand & full & !pop;

  assign wr_entry = '{addr: dataadr, data: writedata};

  // Next-state for pointers, occupancy and the sticky overflow flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    if (clear_overflow) overflow_d = 1'b0;
    if (drop)           overflow_d = 1'b1;
  end

  // State registers; reset discards every entry at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  store_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign out_addr = head.addr;
  assign out_data = head.data;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mips_store_buffer.sv
// tb/tb_mips_store_buffer.sv - directed self-checking bench for mips_store_buffer
module tb_mips_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        clear_overflow;

  int tests  = 0;
  int failed = 0;

  mips_store_buffer #(.DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .memwrite       (memwrite),
    .dataadr        (dataadr),
    .writedata      (writedata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_addr       (out_addr),
    .out_data       (out_data),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    tick();
    memwrite  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;
    out_ready = 1'b0; clear_overflow = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset/idle state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Single store, then drain
    store(32'h10, 32'hDEAD_BEEF);
    chk("one_valid", 32'(out_valid), 32'd1);
    chk("one_addr", out_addr, 32'h10);
    chk("one_data", out_data, 32'hDEAD_BEEF);
    chk("one_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("one_empty", 32'(empty), 32'd1);

    // Five stores into four slots
    for (int i = 1; i <= 5; i++) store(32'h100 + 32'(i), 32'hA0 + 32'(i));
    chk("ovf5_count", 32'(count), 32'd4);
    chk("ovf5_full", 32'(full), 32'd1);
    chk("ovf5_ovf", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovf5_pop_addr", out_addr, 32'h100 + 32'(i));
      chk("ovf5_pop_data", out_data, 32'hA0 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("ovf5_drained", 32'(empty), 32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop reuses the freed slot
    for (int i = 1; i <= 4; i++) store(32'h200 + 32'(i), 32'hB0 + 32'(i));
    out_ready = 1'b1;
    store(32'h205, 32'hB5);
    out_ready = 1'b0;
    chk("fpp_count", 32'(count), 32'd4);
    chk("fpp_ovf", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("fpp_pop_data", out_data, 32'hB0 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("fpp_drained", 32'(empty), 32'd1);

    // Streaming push+pop across three pointer wraps
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) chk("stream_data", out_data, 32'(i - 1));
      else       chk("stream_idle", 32'(out_valid), 32'd0);
      memwrite  = 1'b1;
      dataadr   = 32'h300;
      writedata = 32'(i);
      tick();
      chk("stream_count", 32'(count), 32'd1);
    end
    memwrite = 1'b0;
    chk("stream_last", out_data, 32'd11);
    tick();
    out_ready = 1'b0;
    chk("stream_empty", 32'(empty), 32'd1);

    // Drop coincident with clear: set wins
    for (int i = 0; i < 4; i++) store(32'h400, 32'(i));
    clear_overflow = 1'b1;
    store(32'h404, 32'hFF);
    clear_overflow = 1'b0;
    chk("setwins_ovf", 32'(overflow), 32'd1);
    chk("setwins_count", 32'(count), 32'd4);

    // Asynchronous reset with three entries held
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd3);
    reset = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_ovf", 32'(overflow), 32'd0);
    store(32'h500, 32'h55);
    chk("rst_ignores_store", 32'(count), 32'd0);
    reset = 1'b0;
    tick();

    // Address window filter
    store(32'h0000_0040, 32'h1);
    store(32'hFFFF_0004, 32'h2);
`ifdef MIPS_STORE_BUF_FILTER_EN
    chk("filter_count", 32'(count), 32'd1);
    chk("filter_head", out_addr, 32'hFFFF_0004);
`else
    chk("nofilter_count", 32'(count), 32'd2);
    chk("nofilter_head", out_addr, 32'h0000_0040);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_store_buffer.md
# mips_store_buffer

Downstream consumer of the single-cycle MIPS core's data-store port (`memwrite`, `dataadr`, `writedata`). It captures every store the core issues into a small FIFO and drains the stores, one at a time, to a slower bus through a valid/ready handshake. This decouples the core from peripherals that cannot accept a write every cycle. The core has no stall input, so the buffer never back-pressures the core; stores that do not fit are dropped and flagged.

## Interface
Parameters
- DEPTH, 4: number of FIFO entries; power of two, ≥2.
- MMIO_BASE, 32'hFFFF_0000: base address of the capture window (used only with filter enabled).
- MMIO_MASK, 32'hFFFF_0000: mask for the window compare (used only with filter enabled).

Ports
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high.
- memwrite, input, 1: core store strobe, one store per high cycle.
- dataadr, input, 32: store address.
- writedata, input, 32: store data.
- out_valid, output, 1: head entry is available on the bus.
- out_ready, input, 1: bus accepts the head entry this cycle.
- out_addr, output, 32: head entry address.
- out_data, output, 32: head entry data.
- count, output, $clog2(DEPTH)+1: current occupancy.
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- overflow, output, 1: sticky flag; a store was dropped.
- clear_overflow, input, 1: synchronous clear of the overflow flag.

## Operation
- Occupancy states are derived from `count`: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
- Pop: `pop = out_valid & out_ready`.
- Push candidate: `cand = memwrite` (filter disabled), or `memwrite & in_window` (filter enabled).
- Push accept: `push = cand & (!full | pop)`. When the FIFO is full and a pop happens in the same cycle, the freed slot is reused in that cycle.
- Drop: `cand & full & !pop`. The store is discarded and `overflow` is set to 1 at the next edge.
- Clearing overflow: `clear_overflow` clears the flag. If a drop occurs in the same cycle as the clear, set wins.
- Pointers: write and read pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- `out_valid = !empty`.
- `out_addr` and `out_data` come straight from the head entry, combinationally from the read pointer.
- Once `out_valid` is high, `out_addr` and `out_data` hold stable until the pop.
- Order is strict FIFO; entries are never reordered or merged.
- Non-candidate cycles (memwrite = 0, or out-of-window with filter enabled) leave the FIFO untouched.

## Timing
- Reset values: pointers 0, count 0, empty 1, full 0, out_valid 0, overflow 0. `out_addr` and `out_data` are don't-care when `out_valid` is 0; storage is not reset.
- Latency from store to bus is 1 cycle: a store accepted at edge N gives `out_valid` = 1 after edge N. There is no combinational bypass from `dataadr`/`writedata` to the outputs.
- Throughput is one push and one pop per cycle, sustained.
- Reset asserted mid-operation discards all entries immediately and asynchronously. Stores presented while reset is high are ignored.
- `out_ready` may be high while `out_valid` is 0; this has no effect.

## Configuration
- `MIPS_STORE_BUF_FILTER_EN` defined: only stores with `(dataadr & MMIO_MASK) == MMIO_BASE` are candidates. All other stores are ignored: not buffered, and they do not set `overflow`.
- `MIPS_STORE_BUF_FILTER_EN` undefined: every store is a candidate. The MMIO_BASE and MMIO_MASK parameters are unused.

## Structure
- Shared package `mips_pkg`:
  - typedef `store_req_t` (addr[31:0], data[31:0]).
  - constants `MMIO_BASE_DEFAULT` and `MMIO_MASK_DEFAULT`.
- One sub-module, `store_fifo_mem`: DEPTH × 64-bit storage with a synchronous write port and an asynchronous read port, no reset.
- Pointer, count and flag logic live in `mips_store_buffer`.

## Test plan
- Reset then idle: count=0, empty=1, out_valid=0, overflow=0. Assert reset mid-stream with 3 entries: count=0 immediately.
- Single store (memwrite=1, dataadr=32'h10, writedata=32'hDEAD_BEEF), out_ready=0: next cycle out_valid=1, out_addr=32'h10, out_data=32'hDEAD_BEEF, count=1. Raise out_ready: one cycle later empty=1.
- Five back-to-back stores with DEPTH=4 and out_ready=0: count=4, full=1, overflow=1 after the fifth. Pop order then returns stores 1–4 exactly.
- FIFO full with out_ready=1 and memwrite=1 in the same cycle: count stays 4, overflow stays 0, and the new store appears last.
- Continuous push/pop for 3×DEPTH cycles (pointer wrap), writedata=i: the output sequence is 0,1,2,… with no gaps. Then clear_overflow in the same cycle as a drop: overflow=1.
- With `MIPS_STORE_BUF_FILTER_EN`: a store to 32'h0000_0040 is ignored (count=0); a store to 32'hFFFF_0004 is buffered (count=1). Without the macro, both are buffered (count=2).
